// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU data-memory bridge.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

endpackage

// File: rtl/dmem_timeout.sv
// 8-bit wait counter for the bridge; expire flags the last permitted REQ cycle.
module dmem_timeout #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign expire = en && (count == LAST);

endmodule

// File: rtl/dmem_bridge.sv
// Turns single-cycle CPU data accesses into req/ack bus transactions, stalling
// the CPU until each completes and flagging misaligned or timed-out accesses.
module dmem_bridge
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        RESET,
  input  logic [31:0] MA,
  input  logic [31:0] MWD,
  input  logic        MWR,
  input  logic        MOE,
  output logic [31:0] MRD,
  output logic        STALL,
  output logic        mem_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output state_t      dbg_state
);

  // Bus handshake: bus_req stays high with bus_addr/bus_we/bus_wdata stable
  // until a single-cycle bus_ack completes it; an abort (RESET, timeout or
  // n_rst) drops bus_req without any ack.

  state_t      state, next_state;
  logic        start, fin, fin_fault, expire, we_q;
  logic [31:0] fin_data;

  wire access = MWR | MOE;

  dmem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .n_rst  (n_rst),
    .clr    (state != REQ),
    .en     (state == REQ),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    STALL      = 1'b0;
    start      = 1'b0;
    fin        = 1'b0;
    fin_fault  = 1'b0;
    fin_data   = 32'h0;
    case (state)
      IDLE: begin
        if (access && !RESET) begin
          STALL = 1'b1;
          if (MA[1:0] != 2'b00) begin
            next_state = DONE;
            fin        = 1'b1;
            fin_fault  = 1'b1;
            fin_data   = MWR ? 32'h0 : ERR_DATA;
          end else begin
            next_state = REQ;
            start      = 1'b1;
          end
        end
      end
      REQ: begin
        STALL = 1'b1;
        if (RESET) begin
          next_state = IDLE;
        end else if (bus_ack) begin
          // An ack on the final permitted cycle still wins over the timeout.
          next_state = DONE;
          fin        = 1'b1;
          fin_data   = we_q ? 32'h0 : bus_rdata;
        end else if (expire) begin
          next_state = DONE;
          fin        = 1'b1;
          fin_fault  = 1'b1;
          fin_data   = we_q ? 32'h0 : ERR_DATA;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      we_q      <= 1'b0;
      MRD       <= 32'h0;
      mem_fault <= 1'b0;
    end else begin
      if (start) begin
        bus_addr  <= MA & WORD_MASK;
        bus_wdata <= MWD;
        we_q      <= MWR;
      end
      mem_fault <= fin & fin_fault;
      if (RESET)    MRD <= 32'h0;
      else if (fin) MRD <= fin_data;
    end
  end

  assign bus_req   = (state == REQ);
  assign bus_we    = bus_req & we_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge with a response scoreboard and bus-request monitor.
module tb_dmem_bridge;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] MA = 32'h0;
  logic [31:0] MWD = 32'h0;
  logic        MWR = 1'b0;
  logic        MOE = 1'b0;
  logic [31:0] MRD;
  logic        STALL;
  logic        mem_fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];  // {mem_fault, MRD} expected in DONE
  logic [64:0] bus_q[$];  // {bus_we, bus_addr, bus_wdata} expected at req start
  logic        req_prev = 1'b0;

  dmem_bridge #(.TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .RESET     (RESET),
    .MA        (MA),
    .MWD       (MWD),
    .MWR       (MWR),
    .MOE       (MOE),
    .MRD       (MRD),
    .STALL     (STALL),
    .mem_fault (mem_fault),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents a result.
  always @(negedge clk) begin
    if (n_rst && dbg_state == DONE) begin
      if (exp_q.size() == 0) chk("unexpected_done", {32'h0, mem_fault, MRD}, 65'h1_FFFF_FFFF_FFFF_FFFF);
      else chk("done_resp", {32'h0, mem_fault, MRD}, {32'h0, exp_q.pop_front()});
    end
    if (n_rst && mem_fault && dbg_state != DONE) begin
      errors++;
      $display("FAIL stray_fault actual=1 required=0");
    end
    if (bus_req && !req_prev) begin
      if (bus_q.size() == 0) chk("unexpected_req", {bus_we, bus_addr, bus_wdata}, 65'h1_FFFF_FFFF_FFFF_FFFF);
      else chk("bus_start", {bus_we, bus_addr, bus_wdata}, bus_q.pop_front());
    end
    req_prev = bus_req;
  end

  // Drives one CPU access until DONE; ack_at is the REQ cycle (1-based) carrying bus_ack, 0 = never.
  task automatic cpu_access(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_at, input logic [31:0] rdata,
                            input int exp_stall, input int exp_req, input string name);
    int  st = 0;
    int  rq = 0;
    int  cyc = 0;
    bit  done = 1'b0;
    @(negedge clk);
    MWR = wr; MOE = rd; MA = addr; MWD = wdata;
    while (!done && cyc < 64) begin
      #1;
      if (dbg_state == DONE) begin
        done = 1'b1;
        MWR = 1'b0; MOE = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
      end else begin
        if (STALL)   st++;
        if (bus_req) rq++;
        bus_ack   = (ack_at != 0) && bus_req && (rq == ack_at);
        bus_rdata = bus_ack ? rdata : 32'h0;
        @(negedge clk);
        cyc++;
      end
    end
    chk({name, "_completed"}, 65'(done), 65'd1);
    chk({name, "_stall_cycles"}, 65'(st), 65'(exp_stall));
    chk({name, "_req_cycles"}, 65'(rq), 65'(exp_req));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outputs", {bus_req, bus_we, mem_fault, STALL, MRD}, 65'h0);
    chk("rst_bus_regs", {1'b0, bus_addr, bus_wdata}, 65'h0);
    chk("rst_state", 65'(dbg_state), 65'(IDLE));
    @(negedge clk);
    n_rst = 1'b1;

    // Zero-wait read
    exp_q.push_back({1'b0, 32'h1234_5678});
    bus_q.push_back({1'b0, 32'h100, 32'h0});
    cpu_access(1'b0, 1'b1, 32'h100, 32'h0, 1, 32'h1234_5678, 2, 1, "rd0");

    // Write with three wait cycles; rdata on the ack must not reach MRD
    exp_q.push_back({1'b0, 32'h0});
    bus_q.push_back({1'b1, 32'h20, 32'hCAFE_F00D});
    cpu_access(1'b1, 1'b0, 32'h20, 32'hCAFE_F00D, 4, 32'hFFFF_FFFF, 5, 4, "wr3");

    // Misaligned read: no bus activity
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    cpu_access(1'b0, 1'b1, 32'h102, 32'h0, 1, 32'h0, 1, 0, "misal");

    // Timeout: bus never acks
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    bus_q.push_back({1'b0, 32'h40, 32'h0});
    cpu_access(1'b0, 1'b1, 32'h40, 32'h0, 0, 32'h0, 17, 16, "tmo");

    // Late ack in IDLE is ignored; MRD holds outside DONE
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    chk("late_ack_idle", {bus_req, STALL, mem_fault, 30'h0, dbg_state}, {32'h0, 33'(IDLE)});
    chk("mrd_hold", 65'(MRD), 65'h0_DEAD_BEEF);

    // Abort with RESET in the third REQ cycle
    bus_q.push_back({1'b0, 32'h40, 32'h0});
    @(negedge clk);
    MOE = 1'b1; MA = 32'h40;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_req3", 65'(bus_req), 65'd1);
    RESET = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_req_drop", 65'(bus_req), 65'd0);
    chk("abort_state", 65'(dbg_state), 65'(IDLE));
    chk("abort_stall_in_reset", 65'(STALL), 65'd0);
    chk("abort_mrd", 65'(MRD), 65'd0);
    RESET = 1'b0; MOE = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_no_fault", 65'(mem_fault), 65'd0);

    // Both MWR and MOE: write wins; then a back-to-back read
    exp_q.push_back({1'b0, 32'h0});
    bus_q.push_back({1'b1, 32'h8, 32'h55AA_33CC});
    cpu_access(1'b1, 1'b1, 32'h8, 32'h55AA_33CC, 2, 32'h1111_1111, 3, 2, "both");
    exp_q.push_back({1'b0, 32'h0BAD_F00D});
    bus_q.push_back({1'b0, 32'hC, 32'h0});
    cpu_access(1'b0, 1'b1, 32'hC, 32'h0, 1, 32'h0BAD_F00D, 2, 1, "b2b");

    // Async reset mid-REQ
    bus_q.push_back({1'b0, 32'h80, 32'h0});
    @(negedge clk);
    MOE = 1'b1; MA = 32'h80;
    @(negedge clk);
    #1;
    chk("nrst_req_before", 65'(bus_req), 65'd1);
    n_rst = 1'b0;
    #1;
    chk("nrst_req_async", 65'(bus_req), 65'd0);
    chk("nrst_mrd", 65'(MRD), 65'd0);
    MOE = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;

    // Recovery read with one wait cycle
    exp_q.push_back({1'b0, 32'hA5A5_5A5A});
    bus_q.push_back({1'b0, 32'h200, 32'h0});
    cpu_access(1'b0, 1'b1, 32'h200, 32'h0, 2, 32'hA5A5_5A5A, 3, 2, "rec");

    repeat (3) @(negedge clk);
    chk("exp_q_drained", 65'(exp_q.size()), 65'd0);
    chk("bus_q_drained", 65'(bus_q.size()), 65'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
